// File: rtl/lse_simd_2x12b_sched.sv
// lse_simd_2x12b_sched: pairs scalar LSE requests into dual-lane SIMD beats and unpacks tagged responses in order.
// Define LSE_SCHED_FLUSH_EN to add the HOLD timeout that auto-issues a lone request half-full.
module lse_simd_2x12b_sched #(
    parameter int TAG_W         = 4,
    parameter int RSP_DEPTH     = 4,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [11:0]      req_x,
    input  logic [11:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    input  logic [1:0]       cfg_pe_mode,
    output logic             simd_enable,
    output logic [23:0]      simd_x,
    output logic [23:0]      simd_y,
    output logic [1:0]       simd_pe_mode,
    input  logic [23:0]      simd_result,
    input  logic             simd_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [11:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int EW = 2 * TAG_W + 1;

    if (RSP_DEPTH < 2 || FLUSH_TIMEOUT < 1) begin : g_bad_cfg
        $error("lse_simd_2x12b_sched: need RSP_DEPTH >= 2 and FLUSH_TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;
    state_t state_q, state_d;

    logic [11:0]      x0_q, y0_q, x1_q, y1_q;
    logic [TAG_W-1:0] t0_q, t1_q;
    logic             live_q, sel_q, timeout;
    logic [1:0]       mode_q;
    logic [CW-1:0]    credit_q, tq_cnt_q, rf_cnt_q;
    logic [PW-1:0]    wp_q, mp_q, rp_q;
    // One ring holds each beat from issue until its last lane is consumed; mp trails wp, rp trails mp.
    logic [EW-1:0]    tag_mem [RSP_DEPTH];
    logic [23:0]      res_mem [RSP_DEPTH];
    logic [EW-1:0]    head;
    logic             accept, issue, res_ok, rsp_fire, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign accept   = req_valid && req_ready;
    assign issue    = state_q == ISSUE;
    assign res_ok   = simd_valid && tq_cnt_q != '0;
    assign head     = tag_mem[rp_q];
    assign rsp_fire = rsp_valid && rsp_ready;
    assign pop      = rsp_fire && (sel_q || !head[0]);
    assign busy     = state_q != IDLE || tq_cnt_q != '0 || rf_cnt_q != '0;

`ifdef LSE_SCHED_FLUSH_EN
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    logic [TW-1:0] to_q;
    always_ff @(posedge clk) begin
        if (rst || state_q != HOLD) to_q <= '0;
        else to_q <= to_q + 1'b1;
    end
    assign timeout = state_q == HOLD && to_q == TW'(FLUSH_TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (accept ? HOLD : IDLE) :
                  state_q == HOLD ? ((accept || flush || timeout) ? ISSUE : HOLD) : IDLE;
    end

    always_comb begin
        req_ready   = !rst && (state_q == HOLD || (state_q == IDLE && credit_q != '0));
        simd_enable = !rst && state_q == ISSUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {x0_q, y0_q, t0_q} <= '0;
            {x1_q, y1_q, t1_q, live_q} <= '0;
        end else begin
            if (state_q == IDLE && accept) {x0_q, y0_q, t0_q} <= {req_x, req_y, req_tag};
            if (state_q == HOLD && accept) {x1_q, y1_q, t1_q, live_q} <= {req_x, req_y, req_tag, 1'b1};
            else if (state_q == HOLD && (flush || timeout)) {x1_q, y1_q, live_q} <= {12'h800, 12'h800, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_mem[wp_q] <= {t0_q, t1_q, live_q};
        if (res_ok) res_mem[mp_q] <= simd_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {wp_q, mp_q, rp_q} <= '0;
            {tq_cnt_q, rf_cnt_q, sel_q} <= '0;
            credit_q <= CW'(RSP_DEPTH);
            mode_q <= '0;
        end else begin
            if (issue) wp_q <= inc(wp_q);
            if (res_ok) mp_q <= inc(mp_q);
            if (pop) rp_q <= inc(rp_q);
            tq_cnt_q <= tq_cnt_q + CW'(issue) - CW'(res_ok);
            rf_cnt_q <= rf_cnt_q + CW'(res_ok) - CW'(pop);
            credit_q <= credit_q - CW'(issue) + CW'(pop);
            sel_q <= rsp_fire ? !pop : sel_q;
            if (!busy && state_q == IDLE) mode_q <= cfg_pe_mode;
        end
    end

    assign simd_x       = {x1_q, x0_q};
    assign simd_y       = {y1_q, y0_q};
    assign simd_pe_mode = mode_q;
    assign rsp_valid    = rf_cnt_q != '0;
    assign rsp_result   = !rsp_valid ? '0 : sel_q ? res_mem[rp_q][23:12] : res_mem[rp_q][11:0];
    assign rsp_tag      = !rsp_valid ? '0 : sel_q ? head[TAG_W:1] : head[EW-1:TAG_W+1];
endmodule

// File: tb/tb_lse_simd_2x12b_sched.sv
// tb_lse_simd_2x12b_sched: directed checks of pairing, flush, credits, reset and mode latch.
module tb_lse_simd_2x12b_sched;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, flush = 0, rsp_ready = 0;
    logic [11:0] req_x = 0, req_y = 0;
    logic [3:0]  req_tag = 0;
    logic [1:0]  cfg_pe_mode = 0, simd_pe_mode;
    logic        simd_enable, simd_valid, rsp_valid, busy;
    logic [23:0] simd_x, simd_y, simd_result;
    logic [11:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        auto_dp = 0, man_v = 0, dp_v = 0, dp_pend = 0;
    logic [23:0] man_res = 0, dp_r = 0, dp_nxt = 0;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    assign simd_valid  = auto_dp ? dp_v : man_v;
    assign simd_result = auto_dp ? dp_r : man_res;

    // Datapath stand-in: lane sum, result valid one cycle after the issue strobe.
    always @(negedge clk) begin
        dp_v = dp_pend;
        dp_r = dp_nxt;
        dp_pend = simd_enable;
        dp_nxt = {simd_x[23:12] + simd_y[23:12], simd_x[11:0] + simd_y[11:0]};
    end

    lse_simd_2x12b_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
        .cfg_pe_mode(cfg_pe_mode), .simd_enable(simd_enable), .simd_x(simd_x),
        .simd_y(simd_y), .simd_pe_mode(simd_pe_mode), .simd_result(simd_result),
        .simd_valid(simd_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [3:0] t);
        int k = 0;
        req_valid = 1; req_x = x; req_y = y; req_tag = t;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        check("send_ready", {31'b0, k < 50}, 1);
        @(negedge clk);
        req_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, i, r, en;
        logic acc;
        repeat (2) @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        rst = 0; #1;
        check("rst_ready", req_ready, 1);
        check("rst_enable", simd_enable, 0);
        check("rst_x", simd_x, 0);
        check("rst_y", simd_y, 0);
        check("rst_mode", simd_pe_mode, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", {rsp_tag, rsp_result}, 0);
        check("rst_busy", busy, 0);

        // pair issue and ordered unpack with backpressure
        send(12'h100, 12'h100, 1);
        send(12'h200, 12'h080, 2);
        check("pair_enable", simd_enable, 1);
        check("pair_x", simd_x, 32'h200100);
        check("pair_y", simd_y, 32'h080100);
        @(negedge clk);
        check("pair_enable_1cyc", simd_enable, 0);
        man_res = 24'h2A5160; man_v = 1;
        @(negedge clk); man_v = 0;
        check("pair_rsp_valid", rsp_valid, 1);
        check("pair_rsp0", {rsp_tag, rsp_result}, 32'h1160);
        @(negedge clk);
        check("pair_rsp0_hold", {rsp_tag, rsp_result}, 32'h1160);
        rsp_ready = 1;
        @(negedge clk);
        check("pair_rsp1", {rsp_tag, rsp_result}, 32'h22A5);
        @(negedge clk);
        check("pair_drained", {rsp_valid, busy}, 0);

        // lone request
        send(12'h123, 12'h456, 3);
`ifdef LSE_SCHED_FLUSH_EN
        k = 0;
        while (!simd_enable && k < 30) begin @(negedge clk); k++; end
        check("timeout_latency", k, 8);
`else
        en = 0;
        repeat (12) begin @(negedge clk); if (simd_enable) en++; end
        check("no_auto_issue", en, 0);
        flush = 1;
        @(negedge clk); flush = 0;
`endif
        check("lone_enable", simd_enable, 1);
        check("lone_x", simd_x, 32'h800123);
        check("lone_y", simd_y, 32'h800456);
        @(negedge clk);
        man_res = 24'h000579; man_v = 1;
        @(negedge clk); man_v = 0;
        check("lone_rsp", {rsp_valid, rsp_tag, rsp_result}, 32'h13579);
        @(negedge clk);
        check("lone_no_pad", {rsp_valid, busy}, 0);

        // flush coinciding with the partner accept issues a full beat
        send(12'h010, 12'h020, 5);
        flush = 1;
        send(12'h030, 12'h040, 6);
        flush = 0;
        check("fa_enable", simd_enable, 1);
        check("fa_x", simd_x, 32'h030010);
        check("fa_y", simd_y, 32'h040020);
        @(negedge clk);
        man_res = 24'h070030; man_v = 1;
        @(negedge clk); man_v = 0;
        check("fa_rsp0", {rsp_valid, rsp_tag, rsp_result}, 32'h15030);
        @(negedge clk);
        check("fa_rsp1", {rsp_valid, rsp_tag, rsp_result}, 32'h16070);
        @(negedge clk);
        check("fa_drained", {rsp_valid, busy}, 0);

        // reset with two beats in flight, late results must be dropped
        send(12'h001, 12'h001, 7);
        send(12'h002, 12'h002, 8);
        send(12'h003, 12'h003, 9);
        send(12'h004, 12'h004, 10);
        check("rf_enable2", simd_enable, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rf_ready_in_reset", req_ready, 0);
        rst = 0;
        man_res = 24'h123123; man_v = 1;
        repeat (2) @(negedge clk);
        man_v = 0;
        @(negedge clk);
        check("rf_no_rsp", rsp_valid, 0);
        check("rf_busy", busy, 0);
        check("rf_ready", req_ready, 1);

        // credit stall: full credits admit exactly 4 beats while responses are held
        rsp_ready = 0; auto_dp = 1; i = 0; r = 0;
        for (int c = 0; c < 40; c++) begin
            req_valid = i < 10; req_x = 12'h100 + 12'(i); req_y = 12'(16 * i); req_tag = 4'(i);
            acc = req_valid && req_ready;
            @(negedge clk);
            if (acc) i++;
            if (c == 2) cfg_pe_mode = 2;
        end
        check("stall_accepted", i, 8);
        check("stall_ready_low", req_ready, 0);
        check("stall_mode_held", simd_pe_mode, 0);
        rsp_ready = 1;
        for (int c = 0; c < 200 && r < 10; c++) begin
            req_valid = i < 10; req_x = 12'h100 + 12'(i); req_y = 12'(16 * i); req_tag = 4'(i);
            acc = req_valid && req_ready;
            if (rsp_valid) begin
                check("stream_tag", rsp_tag, r);
                check("stream_result", rsp_result, 32'h100 + 17 * r);
                r++;
            end
            @(negedge clk);
            if (acc) i++;
        end
        req_valid = 0;
        check("stream_count", r, 10);
        check("stream_sent", i, 10);
        check("mode_idle_busy", busy, 0);
        check("mode_before_load", simd_pe_mode, 0);
        @(negedge clk);
        check("mode_loaded", simd_pe_mode, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lse_simd_2x12b_sched.md
# lse_simd_2x12b_sched

Issue scheduler for the dual-lane 12-bit SIMD LSE datapath. Accepts scalar 12-bit LSE requests on a valid/ready stream, pairs them into 24-bit SIMD beats, drives the datapath enable, and tracks in-flight beats by credit. It unpacks returned beats into an in-order, tagged scalar response stream. It sits between the PE request arbiter and one `lse_simd_2x12b` instance.

## Interface
Parameters:
- `TAG_W`, 4: request tag width.
- `RSP_DEPTH`, 4: beats of response buffering. This is also the in-flight credit limit. Must be ≥2.
- `FLUSH_TIMEOUT`, 8: cycles a lone request waits for a partner before a half-empty issue. Must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_x`, `req_y` in 12 each: operands. `req_tag` in `TAG_W`: tag.
- `flush` in 1: force issue of a held lone request.
- `cfg_pe_mode` in 2: requested PE mode. Sampled only in IDLE with an empty pipeline.
- `simd_enable` out 1: one-cycle issue strobe to the datapath.
- `simd_x`, `simd_y` out 24: packed operands. Lane 0 is `[11:0]`, lane 1 is `[23:12]`.
- `simd_pe_mode` out 2: latched mode to the datapath.
- `simd_result` in 24, `simd_valid` in 1: datapath result and its valid.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out 12, `rsp_tag` out `TAG_W`: response payload.
- `busy` out 1: any request held, in flight, or buffered.

## Operation
FSM states: IDLE, HOLD, ISSUE.
- **IDLE.** `req_ready` = 1 when credits > 0. An accepted request is captured into lane 0, and the FSM goes to HOLD with the timeout counter cleared.
- **HOLD.** `req_ready` = 1. Two outcomes:
  - A second accepted request fills lane 1, and the FSM goes to ISSUE with `lane1_live` = 1.
  - Otherwise the FSM goes to ISSUE with `lane1_live` = 0 when any of these holds: `flush`, or counter = `FLUSH_TIMEOUT`-1 (only under the macro). The empty lane is padded with x = y = 12'h800. If `flush` and a request accept occur in the same cycle, the request fills lane 1 and the beat issues full.
- **ISSUE.** `simd_enable` = 1 for exactly one cycle.
  - Credits decrement, and `{tag0, tag1, lane1_live}` is pushed into the in-flight tag queue (depth `RSP_DEPTH`).
  - The FSM then goes to IDLE. `req_ready` = 0 in ISSUE.
- **Credits.** Reset value is `RSP_DEPTH`. Decrement on issue; increment when the last live lane of a buffered beat is popped. Issue and pop in the same cycle leave the count unchanged. Credits never exceed `RSP_DEPTH`.
- **Results.** `simd_valid` pushes `simd_result` plus the head tag entry into the response FIFO. Ordering is strictly in order.
  - Because credits bound in-flight plus buffered beats, the FIFO can never overflow. `simd_valid` with an empty tag queue is a protocol error and is ignored.
- **Unpacking.** Lane 0 is presented first, then lane 1 if live. Pad lanes are never presented.
  - A beat pops on the `rsp_valid && rsp_ready` that consumes its last live lane.
- **Mode.** `simd_pe_mode` loads from `cfg_pe_mode` only when `busy` = 0 and the FSM is in IDLE.

## Timing
- **Reset values.** `req_ready` 0 during reset and 1 the cycle after. `simd_enable` 0, `simd_x`/`simd_y` 0, `simd_pe_mode` 0, `rsp_valid` 0, `rsp_result`/`rsp_tag` 0, `busy` 0. FSM = IDLE, credits = `RSP_DEPTH`, timeout counter 0.
- **Request to issue.**
  - Two back-to-back requests: accepts on cycles n and n+1, `simd_enable` at n+2.
  - Lone request with the macro: accept at n, `simd_enable` at n+`FLUSH_TIMEOUT`+1.
- **Result to response.** `simd_valid` at m gives `rsp_valid` at m+1 (registered FIFO output). Sustained throughput is one lane per cycle on the response side.
- **Backpressure.** `rsp_ready` = 0 holds `rsp_result`/`rsp_tag` stable.
- **Reset mid-operation.** Held lanes, tag queue, FIFO, and credits are discarded. Datapath results returning after reset are ignored, since the tag queue is empty.

## Configuration
- `LSE_SCHED_FLUSH_EN` defined: the HOLD timeout counter is compiled in, and a lone request auto-issues half-full after `FLUSH_TIMEOUT` cycles.
- Undefined: no counter. A lone request waits in HOLD until a partner arrives or `flush` is asserted.

## Test plan
- **Pair issue.** Requests (x=0x100, y=0x100, tag 1) then (0x200, 0x080, tag 2) back-to-back.
  - Expect one `simd_enable` with `simd_x`=0x200100 and `simd_y`=0x080100.
  - With a datapath result 0x2A5160, expect responses 0x160/tag 1 then 0x2A5/tag 2.
- **Timeout flush (macro on, timeout 8).** Single request with tag 3.
  - Expect `simd_enable` 9 cycles after accept, lane 1 padded with 0x800, exactly one response with tag 3.
  - Macro off: no issue until `flush` is pulsed.
- **Credit stall (`RSP_DEPTH`=4).** Hold `rsp_ready`=0 and stream 10 requests.
  - Expect `req_ready` low after 4 beats (8 requests) have issued.
  - Release `rsp_ready`: expect 10 responses with tags in order and no loss.
- **Simultaneous `flush` and accept in HOLD.** Expect a full beat issued with `lane1_live`=1 and two responses.
- **Reset mid-flight.** 2 beats in flight, assert `rst`, then return `simd_valid`.
  - Expect no `rsp_valid`, credits = 4, `busy`=0.
- **Mode latch.** Change `cfg_pe_mode` to 2 while `busy`=1: `simd_pe_mode` holds its old value. It updates to 2 the cycle after the FSM is idle with `busy`=0.
